vga_timing_gen: RTL and testbench

- Raster timing source that drives the color mapper.
- Generates pixel clock enable, horizontal/vertical counters (DrawX, DrawY), sync pulses and blanking for the VGA DAC.
- Sits between the system clock domain and color_mapper/VGA pins. All pixel-rate logic runs on Clk, qualified by pix_en.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_pix_div.sv | 35 +++
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster types and default 640x480@60 timing.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE_D = 640;
  localparam int H_FRONT_D   = 16;
  localparam int H_SYNC_D    = 96;
  localparam int H_BACK_D    = 48;
  localparam int V_VISIBLE_D = 480;
  localparam int V_FRONT_D   = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BACK_D    = 33;

  function automatic int h_total(int vis, int fp, int sy, int bp);
    return vis + fp + sy + bp;
  endfunction

  function automatic int v_total(int vis, int fp, int sy, int bp);
    return vis + fp + sy + bp;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: pix_en strobe and DAC pixel clock.
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic Clk,
  input  logic Reset,
  output logic pix_en,
  output logic VGA_CLK
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_div_chk
    $error("CLK_DIV must be even and at least 2");
  end

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_nxt;

  assign pix_en  = (div_q == D_LAST);
  assign div_nxt = pix_en ? '0 : div_q + DW'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q   <= '0;
      VGA_CLK <= 1'b0;
    end else begin
      div_q   <= div_nxt;
      VGA_CLK <= (div_nxt >= D_HALF);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters, syncs, blanking, line/frame pulses.
// Optional VGA_FRAME_COUNT_EN adds a 16-bit frame_count port.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV   = 2,
  parameter int   H_VISIBLE = H_VISIBLE_D,
  parameter int   H_FRONT   = H_FRONT_D,
  parameter int   H_SYNC    = H_SYNC_D,
  parameter int   H_BACK    = H_BACK_D,
  parameter int   V_VISIBLE = V_VISIBLE_D,
  parameter int   V_FRONT   = V_FRONT_D,
  parameter int   V_SYNC    = V_SYNC_D,
  parameter int   V_BACK    = V_BACK_D,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0
) (
  input  logic   Clk,
  input  logic   Reset,
  output logic   pix_en,
  output logic   VGA_CLK,
  output logic   VGA_HS,
  output logic   VGA_VS,
  output logic   VGA_BLANK_N,
  output logic   VGA_SYNC_N,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   line_start,
  output logic   frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL =
    h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL =
    v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
    $error("raster totals must fit 10-bit counters");
  end

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  // 11-bit bounds so a sync ending at 1024 still compares correctly
  localparam logic [10:0] HS_LO = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_HI = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_LO = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_HI = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS = 11'(V_VISIBLE);

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .Clk     (Clk),
    .Reset   (Reset),
    .pix_en  (pix_en),
    .VGA_CLK (VGA_CLK)
  );

  coord_t h_nxt;
  coord_t v_nxt;
  logic   h_wrap;
  logic   v_wrap;
  logic   hs_act;
  logic   vs_act;
  logic   vis;

  always_comb begin
    h_nxt  = DrawX;
    v_nxt  = DrawY;
    h_wrap = pix_en && (DrawX == H_LAST);
    v_wrap = h_wrap && (DrawY == V_LAST);
    if (pix_en) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = v_wrap ? '0 : DrawY + coord_t'(1);
      end else begin
        h_nxt = DrawX + coord_t'(1);
      end
    end
    // decode from next values so syncs land with their coordinates
    hs_act = ({1'b0, h_nxt} >= HS_LO) && ({1'b0, h_nxt} < HS_HI);
    vs_act = ({1'b0, v_nxt} >= VS_LO) && ({1'b0, v_nxt} < VS_HI);
    vis    = ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_BLANK_N <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= h_nxt;
      DrawY       <= v_nxt;
      VGA_HS      <= hs_act ? HS_POL : ~HS_POL;
      VGA_VS      <= vs_act ? VS_POL : ~VS_POL;
      VGA_BLANK_N <= vis;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

  assign VGA_SYNC_N = 1'b0;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_count_q <= '0;
    end else if (frame_start) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a scaled-down raster.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VV = 8, VF = 2, VSW = 2, VB = 2;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FRAME_CLK = HT * VT * 2;
  localparam int BOUND = 4 * FRAME_CLK;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       pix_en, VGA_CLK, VGA_HS, VGA_VS;
  logic       VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0] DrawX, DrawY;
  logic       line_start, frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  vga_timing_gen #(
    .CLK_DIV   (2),
    .H_VISIBLE (HV),
    .H_FRONT   (HF),
    .H_SYNC    (HSW),
    .H_BACK    (HB),
    .V_VISIBLE (VV),
    .V_FRONT   (VF),
    .V_SYNC    (VSW),
    .V_BACK    (VB),
    .HS_POL    (1'b0),
    .VS_POL    (1'b0)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pix_en      (pix_en),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  // independent raster model advanced on observed pix_en
  int mx = 0, my = 0;
  bit prev_pe = 1'b0;

  always @(negedge Clk) begin
    if (Reset) begin
      mx = 0;
      my = 0;
      prev_pe = 1'b0;
    end else begin
      check("drawx", int'(DrawX), mx);
      check("drawy", int'(DrawY), my);
      check("hs", int'(VGA_HS),
            (mx >= HV + HF && mx < HV + HF + HSW) ? 0 : 1);
      check("vs", int'(VGA_VS),
            (my >= VV + VF && my < VV + VF + VSW) ? 0 : 1);
      check("blank_n", int'(VGA_BLANK_N),
            (mx < HV && my < VV) ? 1 : 0);
      check("line_start", int'(line_start),
            (prev_pe && mx == 0) ? 1 : 0);
      check("frame_start", int'(frame_start),
            (prev_pe && mx == 0 && my == 0) ? 1 : 0);
      prev_pe = pix_en;
      if (pix_en) begin
        if (mx == HT - 1) begin
          mx = 0;
          my = (my == VT - 1) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
      end
    end
  end

  task automatic wait_ls(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge Clk);
      if (line_start) begin
        ok = 1'b1;
        return;
      end
    end
    check("line_start_timeout", 0, 1);
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge Clk);
      if (frame_start) begin
        ok = 1'b1;
        return;
      end
    end
    check("frame_start_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    int n_pe, hs_n, hs_min, hs_max, blank_x;
    int cyc, vs_min, vs_max, y_max;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_drawx", int'(DrawX), 0);
    check("rst_drawy", int'(DrawY), 0);
    check("rst_hs", int'(VGA_HS), 1);
    check("rst_vs", int'(VGA_VS), 1);
    check("rst_blank_n", int'(VGA_BLANK_N), 1);
    check("rst_vga_clk", int'(VGA_CLK), 0);
    check("rst_pix_en", int'(pix_en), 0);
    check("rst_line_start", int'(line_start), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("sync_n", int'(VGA_SYNC_N), 0);
`ifdef VGA_FRAME_COUNT_EN
    check("rst_frame_count", int'(frame_count), 0);
`endif
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("first_pix_en", int'(pix_en), 1);
    check("vga_clk_hi", int'(VGA_CLK), 1);
    @(negedge Clk);
    check("second_pix_en", int'(pix_en), 0);
    check("vga_clk_lo", int'(VGA_CLK), 0);

`ifdef VGA_FRAME_COUNT_EN
    repeat (3) wait_fs(ok);
    @(negedge Clk);
    check("frame_count_3", int'(frame_count), 3);
    force dut.frame_count_q = 16'hffff;
    @(negedge Clk);
    release dut.frame_count_q;
    wait_fs(ok);
    @(negedge Clk);
    check("frame_count_wrap", int'(frame_count), 0);
`endif

    // one full visible line: pixels, sync window, blank edge
    wait_ls(ok);
    if (DrawY >= 10'(VV)) begin
      wait_fs(ok);
    end
    n_pe = 0; hs_n = 0; hs_min = 1023; hs_max = -1;
    blank_x = -1;
    for (int i = 0; i < BOUND; i++) begin
      if (pix_en) begin
        n_pe++;
        if (!VGA_HS) begin
          hs_n++;
          if (int'(DrawX) < hs_min) hs_min = int'(DrawX);
          if (int'(DrawX) > hs_max) hs_max = int'(DrawX);
        end
      end
      if (!VGA_BLANK_N && blank_x < 0) blank_x = int'(DrawX);
      @(negedge Clk);
      if (line_start) break;
    end
    check("line_pixels", n_pe, HT);
    check("hs_width", hs_n, HSW);
    check("hs_first_x", hs_min, HV + HF);
    check("hs_last_x", hs_max, HV + HF + HSW - 1);
    check("blank_x", blank_x, HV);

    // one full frame: period, vsync lines, max DrawY
    wait_fs(ok);
    cyc = 0; vs_min = 1023; vs_max = -1; y_max = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      if (!VGA_VS) begin
        if (int'(DrawY) < vs_min) vs_min = int'(DrawY);
        if (int'(DrawY) > vs_max) vs_max = int'(DrawY);
      end
      if (int'(DrawY) > y_max) y_max = int'(DrawY);
      if (frame_start) break;
    end
    check("frame_clks", cyc, FRAME_CLK);
    check("vs_first_y", vs_min, VV + VF);
    check("vs_last_y", vs_max, VV + VF + VSW - 1);
    check("max_drawy", y_max, VT - 1);

    // reset in mid-frame at (7,5)
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge Clk);
      if (DrawX == 10'd7 && DrawY == 10'd5) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_7_5", int'(ok), 1);
    #1 Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst_drawx", int'(DrawX), 0);
    check("mid_rst_drawy", int'(DrawY), 0);
    check("mid_rst_frame_start", int'(frame_start), 0);
    check("mid_rst_line_start", int'(line_start), 0);
    check("mid_rst_blank_n", int'(VGA_BLANK_N), 1);
    check("mid_rst_hs", int'(VGA_HS), 1);
    #1 Reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      if (frame_start) break;
    end
    check("restart_frame_clks", cyc, FRAME_CLK);

    repeat (HT * 4) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
